// File: rtl/ex_stage_if.sv
// ID/EX -> EX -> EX/MEM signal bundle for the execute stage.
// The master side issues instructions and the slave side (ex_stage) returns results.
interface ex_stage_if #(
    parameter int WIDTH = 16
);
    logic             valid_in;
    logic [3:0]       op;
    logic [3:0]       rd1;
    logic [WIDTH-1:0] regout;
    logic [WIDTH-1:0] opB;
    logic [WIDTH-1:0] alu;
    logic [WIDTH-1:0] R0;
    logic [3:0]       rd1Out;
    logic [WIDTH-1:0] regoutOut;
    logic             valid_out;
    logic             hazard;

    modport master (
        output valid_in, op, rd1, regout, opB,
        input  alu, R0, rd1Out, regoutOut, valid_out, hazard
    );

    modport slave (
        input  valid_in, op, rd1, regout, opB,
        output alu, R0, rd1Out, regoutOut, valid_out, hazard
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU ops, plus iterative shift-add MUL and restoring DIV
// that hold hazard high for ITER cycles while the ID/EX and EX/MEM registers stall.
module ex_stage #(
    parameter int WIDTH = 16,
    parameter int ITER  = 16
) (
    input logic       clk,
    input logic       reset,
    ex_stage_if.slave bus
);
    localparam int CW = $clog2(ITER + 1);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_DIV = 4'b0101;
    localparam logic [3:0] OP_SHL = 4'b0110;
    localparam logic [3:0] OP_SHR = 4'b0111;
    localparam logic [3:0] OP_MOV = 4'b1000;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt_p1;
    logic [WIDTH-1:0]  hi_p1, lo_p1;
    logic [WIDTH-1:0]  mop_p0, ra_p0;
    logic [3:0]        rd_p0;
    logic              is_div_p0;
    logic [WIDTH-1:0]  alu_p1, r0_p1, rego_p1;
    logic [3:0]        rd1_p1;
    logic              vld_p1;
    logic              accept, multi, last;
    logic [2*WIDTH-1:0] step_nxt;

    function automatic logic [WIDTH-1:0] alu_op(input logic [3:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        case (op)
            OP_ADD:  alu_op = a + b;
            OP_SUB:  alu_op = a - b;
            OP_AND:  alu_op = a & b;
            OP_OR:   alu_op = a | b;
            OP_DIV:  alu_op = '1;  // only reached for divide-by-zero
            OP_SHL:  alu_op = a << b[3:0];
            OP_SHR:  alu_op = a >> b[3:0];
            OP_MOV:  alu_op = b;
            default: alu_op = '0;
        endcase
    endfunction

    // {hi,lo} is the running product; lo shifts the multiplier out as product bits shift in.
    function automatic logic [2*WIDTH-1:0] mul_step(input logic [WIDTH-1:0] hi,
                                                    input logic [WIDTH-1:0] lo,
                                                    input logic [WIDTH-1:0] m);
        logic [WIDTH:0] sum;
        sum = {1'b0, hi} + {1'b0, (lo[0] ? m : {WIDTH{1'b0}})};
        return {sum, lo[WIDTH-1:1]};
    endfunction

    // hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] rem,
                                                    input logic [WIDTH-1:0] q,
                                                    input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] rem_lo;
        logic             ge;
        rem_lo = {rem[WIDTH-2:0], q[WIDTH-1]};
        ge     = rem[WIDTH-1] || (rem_lo >= d);
        return {(ge ? rem_lo - d : rem_lo), q[WIDTH-2:0], ge};
    endfunction

    assign accept = bus.valid_in && (state == IDLE);
    assign multi  = (bus.op == OP_MUL) || ((bus.op == OP_DIV) && (bus.opB != '0));
    assign last   = (state == BUSY) && (cnt_p1 == CW'(ITER - 1));

    always_comb begin
        step_nxt = is_div_p0 ? div_step(hi_p1, lo_p1, mop_p0)
                             : mul_step(hi_p1, lo_p1, mop_p0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && multi) state_nxt = BUSY;
            BUSY:    if (last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // p0: operands latched on acceptance; p1: iteration state and registered results
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_p1    <= '0;
            hi_p1     <= '0;
            lo_p1     <= '0;
            mop_p0    <= '0;
            ra_p0     <= '0;
            rd_p0     <= '0;
            is_div_p0 <= 1'b0;
            alu_p1    <= '0;
            r0_p1     <= '0;
            rd1_p1    <= '0;
            rego_p1   <= '0;
            vld_p1    <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            if (accept) begin
                ra_p0     <= bus.regout;
                rd_p0     <= bus.rd1;
                is_div_p0 <= (bus.op == OP_DIV);
                cnt_p1    <= '0;
                if (multi) begin
                    hi_p1  <= '0;
                    lo_p1  <= (bus.op == OP_DIV) ? bus.regout : bus.opB;
                    mop_p0 <= (bus.op == OP_DIV) ? bus.opB : bus.regout;
                end else begin
                    alu_p1  <= alu_op(bus.op, bus.regout, bus.opB);
                    r0_p1   <= (bus.op == OP_DIV) ? bus.regout : '0;
                    rd1_p1  <= bus.rd1;
                    rego_p1 <= bus.regout;
                    vld_p1  <= 1'b1;
                end
            end else if (state == BUSY) begin
                hi_p1  <= step_nxt[2*WIDTH-1:WIDTH];
                lo_p1  <= step_nxt[WIDTH-1:0];
                cnt_p1 <= cnt_p1 + CW'(1);
                if (last) begin
                    alu_p1  <= step_nxt[WIDTH-1:0];
                    r0_p1   <= step_nxt[2*WIDTH-1:WIDTH];
                    rd1_p1  <= rd_p0;
                    rego_p1 <= ra_p0;
                    vld_p1  <= 1'b1;
                end
            end
        end
    end

    assign bus.alu       = alu_p1;
    assign bus.R0        = r0_p1;
    assign bus.rd1Out    = rd1_p1;
    assign bus.regoutOut = rego_p1;
    assign bus.valid_out = vld_p1;
    assign bus.hazard    = (state == BUSY);
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: a table of single-cycle vectors plus hand-written
// MUL/DIV, stall, and asynchronous-reset sequences.
module tb_ex_stage;
    localparam int WIDTH = 16;
    localparam int ITER  = 16;

    logic clk = 1'b0;
    logic reset;
    int   nvec  = 0;
    int   nfail = 0;

    ex_stage_if #(.WIDTH(WIDTH)) bus ();

    ex_stage #(.WIDTH(WIDTH), .ITER(ITER)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  op;
        logic [3:0]  rd;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] ealu;
        logic [15:0] er0;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [3:0] rd,
                         input logic [15:0] a, input logic [15:0] b);
        bus.valid_in = v;
        bus.op       = op;
        bus.rd1      = rd;
        bus.regout   = a;
        bus.opB      = b;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_alu"},    bus.alu, 0);
        chk({tag, "_R0"},     bus.R0, 0);
        chk({tag, "_rd1Out"}, bus.rd1Out, 0);
        chk({tag, "_regOut"}, bus.regoutOut, 0);
        chk({tag, "_valid"},  bus.valid_out, 0);
        chk({tag, "_hazard"}, bus.hazard, 0);
    endtask

    task automatic run_single(input vec_t v);
        drive(1'b1, v.op, v.rd, v.a, v.b);
        @(posedge clk); #1;
        chk("sc_alu",    bus.alu, v.ealu);
        chk("sc_R0",     bus.R0, v.er0);
        chk("sc_rd1Out", bus.rd1Out, v.rd);
        chk("sc_regOut", bus.regoutOut, v.a);
        chk("sc_valid",  bus.valid_out, 1);
        chk("sc_hazard", bus.hazard, 0);
    endtask

    task automatic run_multi(input logic [3:0] op, input logic [3:0] rd,
                             input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] ealu, input logic [15:0] er0,
                             input logic [15:0] prev_alu, input bit disturb);
        int bad;
        drive(1'b1, op, rd, a, b);
        @(posedge clk); #1;
        chk("mc_acc_hazard", bus.hazard, 1);
        chk("mc_acc_valid",  bus.valid_out, 0);
        chk("mc_acc_hold",   bus.alu, prev_alu);
        if (disturb) drive(1'b1, 4'h0, 4'h9, 16'h0001, 16'h0001);
        else         drive(1'b0, 4'h0, 4'h0, 16'h0000, 16'h0000);
        bad = 0;
        for (int i = 1; i < ITER; i++) begin
            @(posedge clk); #1;
            if (bus.hazard !== 1'b1 || bus.valid_out !== 1'b0 || bus.alu !== prev_alu) bad++;
        end
        chk("mc_busy_cycles", bad, 0);
        @(posedge clk); #1;
        chk("mc_done_hazard", bus.hazard, 0);
        chk("mc_done_valid",  bus.valid_out, 1);
        chk("mc_alu",         bus.alu, ealu);
        chk("mc_R0",          bus.R0, er0);
        chk("mc_rd1Out",      bus.rd1Out, rd);
        chk("mc_regOut",      bus.regoutOut, a);
    endtask

    initial begin
        tbl[0]  = '{4'h0, 4'h3, 16'h0002, 16'h0003, 16'h0005, 16'h0000}; // ADD
        tbl[1]  = '{4'h1, 4'h1, 16'h0000, 16'h0001, 16'hFFFF, 16'h0000}; // SUB wrap
        tbl[2]  = '{4'h2, 4'h2, 16'hF0F0, 16'h3C3C, 16'h3030, 16'h0000}; // AND
        tbl[3]  = '{4'h3, 4'h4, 16'h1200, 16'h0034, 16'h1234, 16'h0000}; // OR
        tbl[4]  = '{4'h6, 4'h5, 16'h0001, 16'h0014, 16'h0010, 16'h0000}; // SHL uses opB[3:0]
        tbl[5]  = '{4'h7, 4'h6, 16'h8000, 16'h000F, 16'h0001, 16'h0000}; // SHR
        tbl[6]  = '{4'h8, 4'h7, 16'h1111, 16'hBEEF, 16'hBEEF, 16'h0000}; // MOV
        tbl[7]  = '{4'h9, 4'h8, 16'h1234, 16'h5678, 16'h0000, 16'h0000}; // undefined
        tbl[8]  = '{4'hF, 4'hA, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000}; // undefined
        tbl[9]  = '{4'h5, 4'hB, 16'h0007, 16'h0000, 16'hFFFF, 16'h0007}; // DIV by zero
        tbl[10] = '{4'h0, 4'hC, 16'hFFFF, 16'h0002, 16'h0001, 16'h0000}; // ADD wrap
        tbl[11] = '{4'h1, 4'hD, 16'h0010, 16'h0003, 16'h000D, 16'h0000}; // SUB

        reset = 1'b0;
        drive(1'b0, 4'h0, 4'h0, 16'h0000, 16'h0000);
        #12;
        chk_zero("por");
        @(posedge clk); #1;
        reset = 1'b1;

        for (int i = 0; i < 12; i++) run_single(tbl[i]);

        drive(1'b0, 4'h0, 4'h1, 16'h5555, 16'h5555);
        @(posedge clk); #1;
        chk("idle_valid", bus.valid_out, 0);
        chk("idle_hold",  bus.alu, 16'h000D);

        run_multi(4'h4, 4'h2, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 16'h000D, 1'b1);
        @(posedge clk); #1;
        chk("post_mul_add_alu",   bus.alu, 16'h0002);
        chk("post_mul_add_rd",    bus.rd1Out, 4'h9);
        chk("post_mul_add_valid", bus.valid_out, 1);
        run_single('{4'h1, 4'h3, 16'h0000, 16'h0001, 16'hFFFF, 16'h0000});
        drive(1'b0, 4'h0, 4'h0, 16'h0000, 16'h0000);

        run_multi(4'h5, 4'h4, 16'h0007, 16'h0002, 16'h0003, 16'h0001, 16'hFFFF, 1'b0);
        run_multi(4'h4, 4'h5, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 16'h0003, 1'b0);
        run_multi(4'h5, 4'h6, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 16'h0001, 1'b0);

        // Abort a DIV partway through with an asynchronous reset between edges.
        drive(1'b1, 4'h5, 4'h7, 16'h0007, 16'h0002);
        @(posedge clk); #1;
        drive(1'b0, 4'h0, 4'h0, 16'h0000, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
        end
        chk("abort_busy", bus.hazard, 1);
        #2 reset = 1'b0;
        #1;
        chk_zero("async");
        @(posedge clk); #1;
        chk("abort_valid", bus.valid_out, 0);
        reset = 1'b1;
        run_single('{4'h0, 4'h8, 16'h0004, 16'h0005, 16'h0009, 16'h0000});
        drive(1'b0, 4'h0, 4'h0, 16'h0000, 16'h0000);
        @(posedge clk); #1;
        chk("final_valid", bus.valid_out, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
